// File: rtl/step_clock_gen.sv
// Debounced single-step clock generator: one clean CpuClk pulse per button press.
// Optional free-run stepping is built only when STEP_AUTO_RUN_EN is defined.
module step_clock_gen #(
  parameter int DebounceCycles = 16000,
  parameter int HighCycles     = 8,
  parameter int DividerCount   = 8000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Button,
  input  logic        RunMode,
  output logic        CpuClk,
  output logic        StepPulse,
  output logic        Pressed,
  output logic [15:0] StepCount
);

  localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int HiW  = $clog2(HighCycles + 1);
  localparam logic [CntW-1:0] DbLast = CntW'(DebounceCycles - 1);
  localparam logic [HiW-1:0]  HiLoad = HiW'(HighCycles);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t            state_reg, state_next;
  logic [CntW-1:0]   db_cnt_reg, db_cnt_next;
  logic [HiW-1:0]    high_cnt_reg, high_cnt_next;
  logic [15:0]       step_count_reg, step_count_next;
  logic              pad_reg, meta_reg, btn_s_reg;
  logic              cpu_clk_reg, step_pulse_reg;
  logic              press_strobe;
  logic              step_next;

  // Pad capture flop feeding the two-stage synchronizer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pad_reg   <= 1'b0;
      meta_reg  <= 1'b0;
      btn_s_reg <= 1'b0;
    end else begin
      pad_reg   <= Button;
      meta_reg  <= pad_reg;
      btn_s_reg <= meta_reg;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      db_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      db_cnt_reg <= db_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    db_cnt_next  = db_cnt_reg;
    press_strobe = 1'b0;
    case (state_reg)
      IDLE: begin
        if (btn_s_reg) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s_reg) begin
          state_next = IDLE;
        end else if (db_cnt_reg == DbLast) begin
          state_next   = HELD;
          press_strobe = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + CntW'(1);
        end
      end
      HELD: begin
        if (!btn_s_reg) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back high returns to HELD without a second strobe.
        if (btn_s_reg) begin
          state_next = HELD;
        end else if (db_cnt_reg == DbLast) begin
          state_next = IDLE;
        end else begin
          db_cnt_next = db_cnt_reg + CntW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef STEP_AUTO_RUN_EN
  localparam int DivW = (DividerCount > 1) ? $clog2(DividerCount) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DividerCount - 1);

  logic [DivW-1:0] div_cnt_reg, div_cnt_next;
  logic            div_strobe;

  always_comb begin
    div_cnt_next = '0;
    div_strobe   = 1'b0;
    if (RunMode) begin
      if (div_cnt_reg == DivLast) begin
        div_strobe = 1'b1;
      end else begin
        div_cnt_next = div_cnt_reg + DivW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
    end
  end

  // Button presses still debounce in free-run, but never step the CPU.
  assign step_next = RunMode ? div_strobe : press_strobe;
`else
  logic unused_run_mode;
  assign unused_run_mode = RunMode;
  assign step_next       = press_strobe;
`endif

  always_comb begin
    high_cnt_next = high_cnt_reg;
    if (high_cnt_reg != '0) begin
      high_cnt_next = high_cnt_reg - HiW'(1);
    end else if (step_pulse_reg) begin
      high_cnt_next = HiLoad;
    end
  end

  assign step_count_next = step_next ? (step_count_reg + 16'd1) : step_count_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      high_cnt_reg   <= '0;
      cpu_clk_reg    <= 1'b0;
      step_pulse_reg <= 1'b0;
      step_count_reg <= '0;
    end else begin
      high_cnt_reg   <= high_cnt_next;
      cpu_clk_reg    <= (high_cnt_next != '0);
      step_pulse_reg <= step_next;
      step_count_reg <= step_count_next;
    end
  end

  assign CpuClk    = cpu_clk_reg;
  assign StepPulse = step_pulse_reg;
  assign StepCount = step_count_reg;
  assign Pressed   = (state_reg == HELD) || (state_reg == RELEASE_WAIT);

endmodule
